sha256_msg_schedule: RTL and testbench

- Producer side of the per-round W_t/K_t interface consumed by the SHA-256 round datapath.
- Accepts one 512-bit padded message block and expands it into the 64-word message schedule W_0..W_63 using a 16-word sliding window.
- Streams one W_t with its K_t per handshake beat to the round controller.
- Sits between the message padder/block buffer and the compression round logic.

---
 rtl/sha256_pkg.sv | 44 ++++
 rtl/sha256_msg_schedule_if.sv | 27 ++
 rtl/sha256_k_rom.sv | 11 +
 rtl/sha256_msg_schedule.sv | 79 +++++++
 tb/tb_sha256_msg_schedule.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, schedule FSM states, round constants
// and the small-sigma functions used for message expansion.
package sha256_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned ROUNDS = 64;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {
      StIdle,
      StStream
   } state_e;

   localparam word_t K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // ROTR7 ^ ROTR18 ^ SHR3
   function automatic word_t sigma0(word_t x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   // ROTR17 ^ ROTR19 ^ SHR10
   function automatic word_t sigma1(word_t x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-in / W_t-out handshake bundle of the message scheduler. The master
// modport is the scheduler itself; the slave modport is its environment.
interface sha256_msg_schedule_if;
   import sha256_pkg::*;

   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         w_valid;
   logic         w_ready;
   word_t        w_t;
   word_t        k_t;
   logic [5:0]   t_idx;
   logic         w_last;
   logic         busy;

   modport master (
      input  blk_valid, blk_data, w_ready,
      output blk_ready, w_valid, w_t, k_t, t_idx, w_last, busy
   );

   modport slave (
      output blk_valid, blk_data, w_ready,
      input  blk_ready, w_valid, w_t, k_t, t_idx, w_last, busy
   );

endinterface

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup, shared by round controllers.
module sha256_k_rom
   import sha256_pkg::*;
(
   input  logic [5:0] addr,
   output word_t      k
);

   assign k = K[addr];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W_0..W_{N-1} with a
// 16-word sliding window and streams each W_t with its K_t.
module sha256_msg_schedule
   import sha256_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = ROUNDS,
   parameter int unsigned WORD_W     = sha256_pkg::WORD_W
) (
   input logic                   clk,
   input logic                   rst_n,
   sha256_msg_schedule_if.master bus
);

   localparam logic [5:0] LastT = 6'(NUM_ROUNDS - 1);

   state_e            state_q;
   logic [WORD_W-1:0] window_q [16];
   logic [5:0]        t_q;
   logic [WORD_W-1:0] next_word;
   logic              last_t;
   word_t             k_val;

   // window[0] is W_t, so window[1]/[9]/[14] are W_{t+1}/W_{t+9}/W_{t+14}
   always_comb begin
      next_word = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];
   end

   assign last_t = (t_q == LastT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         t_q     <= '0;
         for (int i = 0; i < 16; i++) begin
            window_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.blk_valid) begin
                  for (int i = 0; i < 16; i++) begin
                     window_q[i] <= bus.blk_data[511 - 32*i -: 32];
                  end
                  t_q     <= '0;
                  state_q <= StStream;
               end
            end
            StStream: begin
               if (bus.w_ready) begin
                  if (last_t) begin
                     state_q <= StIdle;
                  end else begin
                     for (int i = 0; i < 15; i++) begin
                        window_q[i] <= window_q[i+1];
                     end
                     window_q[15] <= next_word;
                     t_q          <= t_q + 6'd1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   sha256_k_rom u_k_rom (
      .addr (t_q),
      .k    (k_val)
   );

   assign bus.blk_ready = (state_q == StIdle);
   assign bus.w_valid   = (state_q == StStream);
   assign bus.busy      = (state_q == StStream);
   assign bus.w_t       = window_q[0];
   assign bus.k_t       = k_val;
   assign bus.t_idx     = t_q;
   assign bus.w_last    = (state_q == StStream) && last_t;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a direct W_t recurrence
// and K_t values derived from cube roots of the first 64 primes.
module tb_sha256_msg_schedule;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sha256_msg_schedule_if bus ();

   sha256_msg_schedule #(
      .NUM_ROUNDS (64),
      .WORD_W     (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   localparam logic [511:0] Abc = {32'h61626380, 448'h0, 32'h00000018};

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] k_model [64];
   logic [31:0] exp_w [64];
   logic [31:0] obs_w [64];
   logic [31:0] obs_k [64];

   function automatic logic [31:0] rotr(logic [31:0] x, int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] s0(logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic build_k();
      int p = 2;
      for (int i = 0; i < 64; i++) begin
         real c;
         real f;
         bit  prime;
         do begin
            prime = 1'b1;
            for (int d = 2; d * d <= p; d++) if (p % d == 0) prime = 1'b0;
            if (!prime) p++;
         end while (!prime);
         c = $pow(real'(p), 1.0 / 3.0);
         f = c - $floor(c);
         k_model[i] = 32'(longint'($floor(f * 4294967296.0)));
         p++;
      end
   endtask

   task automatic build_model(input logic [511:0] d);
      for (int i = 0; i < 16; i++) exp_w[i] = d[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         exp_w[i] = s1(exp_w[i-2]) + exp_w[i-7] + s0(exp_w[i-15]) + exp_w[i-16];
      end
   endtask

   // Called at a negedge while idle; returns at the negedge of the first beat.
   task automatic send_block(input string tag, input logic [511:0] d);
      chk({tag, " blk_ready before send"}, 32'(bus.blk_ready), 32'd1);
      bus.blk_valid = 1'b1;
      bus.blk_data  = d;
      @(negedge clk);
      bus.blk_valid = 1'b0;
   endtask

   // Consume beats from the current negedge until stop_t beats have been taken.
   task automatic drain(input string tag, input int stall_pct, input bit pulse_blk,
                        input int stop_t);
      int t = 0;
      int cyc = 0;
      while (t < stop_t && cyc < 3000) begin
         chk($sformatf("%s w_valid t=%0d", tag, t), 32'(bus.w_valid), 32'd1);
         chk($sformatf("%s w_t t=%0d", tag, t), bus.w_t, exp_w[t]);
         chk($sformatf("%s t_idx t=%0d", tag, t), 32'(bus.t_idx), 32'(t));
         chk($sformatf("%s k_t t=%0d", tag, t), bus.k_t, k_model[t]);
         chk($sformatf("%s w_last t=%0d", tag, t), 32'(bus.w_last), 32'(t == 63));
         chk($sformatf("%s blk_ready t=%0d", tag, t), 32'(bus.blk_ready), 32'd0);
         chk($sformatf("%s busy t=%0d", tag, t), 32'(bus.busy), 32'd1);
         obs_w[t] = bus.w_t;
         obs_k[t] = bus.k_t;
         bus.w_ready = ($urandom_range(99) >= stall_pct);
         if (pulse_blk) begin
            bus.blk_valid = 1'($urandom_range(1));
            bus.blk_data  = {16{$urandom()}};
         end
         @(negedge clk);
         cyc++;
         if (bus.w_ready) t++;
      end
      bus.w_ready = 1'b0;
      if (pulse_blk) bus.blk_valid = 1'b0;
      chk({tag, " beat budget"}, 32'(cyc < 3000), 32'd1);
      if (stop_t == 64) begin
         chk({tag, " idle w_valid"}, 32'(bus.w_valid), 32'd0);
         chk({tag, " idle w_last"}, 32'(bus.w_last), 32'd0);
         chk({tag, " idle busy"}, 32'(bus.busy), 32'd0);
         chk({tag, " idle blk_ready"}, 32'(bus.blk_ready), 32'd1);
      end
   endtask

   initial begin
      logic [511:0] blk_a;
      logic [511:0] blk_b;
      logic [31:0]  ones_w16;

      bus.blk_valid = 1'b0;
      bus.blk_data  = '0;
      bus.w_ready   = 1'b0;
      build_k();

      // Reset state
      #1;
      chk("rst w_valid", 32'(bus.w_valid), 32'd0);
      chk("rst w_last", 32'(bus.w_last), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst blk_ready", 32'(bus.blk_ready), 32'd1);
      chk("rst w_t", bus.w_t, 32'd0);
      chk("rst t_idx", 32'(bus.t_idx), 32'd0);
      chk("rst k_t", bus.k_t, 32'h428a2f98);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Test 1: "abc" block, no stalls
      build_model(Abc);
      send_block("abc", Abc);
      drain("abc", 0, 1'b0, 64);
      chk("abc W16", obs_w[16], 32'h61626380);
      chk("abc W17", obs_w[17], 32'h000f0000);
      chk("abc W15", obs_w[15], 32'h00000018);
      chk("abc K0", obs_k[0], 32'h428a2f98);
      chk("abc K63", obs_k[63], 32'hc67178f2);

      // Test 2: same block under random backpressure
      @(negedge clk);
      send_block("stall", Abc);
      drain("stall", 45, 1'b0, 64);

      // Test 3: blk_valid held high across two different blocks
      @(negedge clk);
      blk_a = {16{$urandom()}} ^ {512{1'b1}};
      blk_b = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
      chk("b2b blk_ready", 32'(bus.blk_ready), 32'd1);
      bus.blk_valid = 1'b1;
      bus.blk_data  = blk_a;
      @(negedge clk);
      bus.blk_data  = blk_b;
      build_model(blk_a);
      drain("b2b_a", 0, 1'b0, 64);
      @(negedge clk);
      bus.blk_valid = 1'b0;
      build_model(blk_b);
      chk("b2b second W0", bus.w_t, blk_b[511:480]);
      drain("b2b_b", 20, 1'b0, 64);

      // Test 4: reset at t=30, then re-send "abc"
      @(negedge clk);
      build_model(Abc);
      send_block("rst", Abc);
      drain("rst_pre", 10, 1'b0, 30);
      chk("rst t_idx at abort", 32'(bus.t_idx), 32'd30);
      rst_n = 1'b0;
      #1;
      chk("midrst w_valid", 32'(bus.w_valid), 32'd0);
      chk("midrst blk_ready", 32'(bus.blk_ready), 32'd1);
      chk("midrst busy", 32'(bus.busy), 32'd0);
      chk("midrst t_idx", 32'(bus.t_idx), 32'd0);
      chk("midrst w_t", bus.w_t, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst w_valid", 32'(bus.w_valid), 32'd0);
      send_block("rst_again", Abc);
      drain("rst_again", 0, 1'b0, 64);

      // Test 5: all-ones block exercises wrap-around adds
      @(negedge clk);
      build_model({512{1'b1}});
      send_block("ones", {512{1'b1}});
      drain("ones", 0, 1'b0, 64);
      ones_w16 = s1(32'hffffffff) + 32'hffffffff + s0(32'hffffffff) + 32'hffffffff;
      chk("ones W16", obs_w[16], ones_w16);

      // Test 6: blk_valid pulsed with junk while streaming
      @(negedge clk);
      blk_a = {16{$urandom()}};
      build_model(blk_a);
      send_block("pulse", blk_a);
      drain("pulse", 30, 1'b1, 64);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
